// File: rtl/rtc_bus_master.sv
// ---------------------------------------------------------------------------
// rtc_bus_master
// Master for the RTC multiplexed address/data bus. Runs one complete read or
// write transaction (address phase, then data phase) per accepted command.
// Every phase length is a parameter timed by an internal down-counter.
//
// Optional feature: define RTC_CMD_BUF_EN to add a one-entry command buffer
// that accepts a command while busy and chains it back-to-back after DONE.
// ---------------------------------------------------------------------------
module rtc_bus_master #(
    parameter int DW    = 8,
    parameter int CNT_W = 4,
    parameter int T_AS  = 1,
    parameter int T_AW  = 2,
    parameter int T_AH  = 1,
    parameter int T_DS  = 1,
    parameter int T_ST  = 2,
    parameter int T_RC  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          rw,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          cmd_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    input  logic [DW-1:0] ad_in,
    output logic [DW-1:0] ad_out,
    output logic          ad_oe,
    output logic          a_d,
    output logic          cs,
    output logic          rd,
    output logic          wr
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ADDR_SETUP = 3'd1;
    localparam logic [2:0] S_ADDR_WR    = 3'd2;
    localparam logic [2:0] S_ADDR_HOLD  = 3'd3;
    localparam logic [2:0] S_DATA_SETUP = 3'd4;
    localparam logic [2:0] S_STROBE     = 3'd5;
    localparam logic [2:0] S_RECOVER    = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    // Counter load values: a phase of T cycles loads T-1 and ends at zero.
    localparam logic [CNT_W-1:0] C_AS = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] C_AW = CNT_W'(T_AW - 1);
    localparam logic [CNT_W-1:0] C_AH = CNT_W'(T_AH - 1);
    localparam logic [CNT_W-1:0] C_DS = CNT_W'(T_DS - 1);
    localparam logic [CNT_W-1:0] C_ST = CNT_W'(T_ST - 1);
    localparam logic [CNT_W-1:0] C_RC = CNT_W'(T_RC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic             accept;
    logic             phase_end;
    logic             is_idle;

    // Command to chain straight out of DONE (buffered or arriving that cycle).
    logic             next_valid;
    logic             next_rw;
    logic [DW-1:0]    next_addr;
    logic [DW-1:0]    next_wdata;

    assign is_idle   = (state_q == S_IDLE);
    assign accept    = start & cmd_ready;
    assign phase_end = (cnt_q == '0);

`ifdef RTC_CMD_BUF_EN
    logic          buf_valid_q, buf_valid_d;
    logic          buf_rw_q, buf_rw_d;
    logic [DW-1:0] buf_addr_q, buf_addr_d;
    logic [DW-1:0] buf_wdata_q, buf_wdata_d;

    assign cmd_ready  = is_idle | ~buf_valid_q;

    // In DONE the buffer is consumed; a command accepted during DONE bypasses it.
    assign next_valid = buf_valid_q | (accept & (state_q == S_DONE));
    assign next_rw    = buf_valid_q ? buf_rw_q    : rw;
    assign next_addr  = buf_valid_q ? buf_addr_q  : addr;
    assign next_wdata = buf_valid_q ? buf_wdata_q : wdata;

    // Buffer next state: fill while busy, drain in DONE.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rw_d    = buf_rw_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        if (state_q == S_DONE) begin
            buf_valid_d = 1'b0;
        end else if (accept && !is_idle) begin
            buf_valid_d = 1'b1;
            buf_rw_d    = rw;
            buf_addr_d  = addr;
            buf_wdata_d = wdata;
        end
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_rw_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rw_q    <= buf_rw_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end
`else
    assign cmd_ready  = is_idle;
    assign next_valid = 1'b0;
    assign next_rw    = 1'b0;
    assign next_addr  = '0;
    assign next_wdata = '0;
`endif

    // Transaction sequencer: phase transitions, counter, command and read capture.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_ADDR_SETUP;
                    cnt_d   = C_AS;
                end
            end
            S_ADDR_SETUP: begin
                if (phase_end) begin
                    state_d = S_ADDR_WR;
                    cnt_d   = C_AW;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ADDR_WR: begin
                if (phase_end) begin
                    state_d = S_ADDR_HOLD;
                    cnt_d   = C_AH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ADDR_HOLD: begin
                if (phase_end) begin
                    state_d = S_DATA_SETUP;
                    cnt_d   = C_DS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA_SETUP: begin
                if (phase_end) begin
                    state_d = S_STROBE;
                    cnt_d   = C_ST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (phase_end) begin
                    // The RTC has had the full strobe width to drive the bus.
                    if (rw_q) begin
                        rdata_d = ad_in;
                    end
                    state_d = S_RECOVER;
                    cnt_d   = C_RC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RECOVER: begin
                if (phase_end) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (next_valid) begin
                    rw_d    = next_rw;
                    addr_d  = next_addr;
                    wdata_d = next_wdata;
                    state_d = S_ADDR_SETUP;
                    cnt_d   = C_AS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin decode from registered state only, so start never reaches a pin combinationally.
    always_comb begin
        a_d    = 1'b1;
        cs     = 1'b1;
        rd     = 1'b1;
        wr     = 1'b1;
        ad_oe  = 1'b0;
        ad_out = '0;
        case (state_q)
            S_ADDR_SETUP, S_ADDR_HOLD: begin
                a_d    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q;
            end
            S_ADDR_WR: begin
                a_d    = 1'b0;
                cs     = 1'b0;
                wr     = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q;
            end
            S_DATA_SETUP, S_RECOVER: begin
                // Write data is driven through setup and held through recovery.
                if (!rw_q) begin
                    ad_oe  = 1'b1;
                    ad_out = wdata_q;
                end
            end
            S_STROBE: begin
                cs = 1'b0;
                if (rw_q) begin
                    rd = 1'b0;
                end else begin
                    wr     = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = wdata_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy  = !is_idle;
    assign done  = (state_q == S_DONE);
    assign rdata = rdata_q;

    // State, counter and command registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_master.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_master
// Self-checking bench for rtc_bus_master. Expected pin behaviour comes from a
// phase timeline built from the phase lengths; table vectors, random
// transactions and hand-written corner sequences are checked against it.
// Builds with or without RTC_CMD_BUF_EN.
// ---------------------------------------------------------------------------
module tb_rtc_bus_master;

`ifdef RTC_CMD_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start2;
    logic       rw;
    logic [7:0] addr, wdata, ad_in;

    logic       cmd_ready0, busy0, done0, ad_oe0, a_d0, cs0, rd0, wr0;
    logic [7:0] rdata0, ad_out0;
    logic       cmd_ready1, busy1, done1, ad_oe1, a_d1, cs1, rd1, wr1;
    logic [7:0] rdata1, ad_out1;

    always #5 clk = ~clk;

    rtc_bus_master dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .cmd_ready(cmd_ready0), .busy(busy0), .done(done0), .rdata(rdata0),
        .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(ad_oe0),
        .a_d(a_d0), .cs(cs0), .rd(rd0), .wr(wr0)
    );

    rtc_bus_master #(.T_AW(4), .T_ST(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
        .cmd_ready(cmd_ready1), .busy(busy1), .done(done1), .rdata(rdata1),
        .ad_in(ad_in), .ad_out(ad_out1), .ad_oe(ad_oe1),
        .a_d(a_d1), .cs(cs1), .rd(rd1), .wr(wr1)
    );

    typedef struct packed {
        logic       a_d, cs, rd, wr, oe;
        logic [7:0] ad;
        logic       busy, done, rdy;
        logic [7:0] rdata;
    } obs_t;

    typedef struct {
        logic       rw;
        logic [7:0] a, w, d;
        logic [7:0] exp_rdata;
        int         exp_done;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_rd[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0)
            o = '{a_d0, cs0, rd0, wr0, ad_oe0, ad_out0, busy0, done0, cmd_ready0, rdata0};
        else
            o = '{a_d1, cs1, rd1, wr1, ad_oe1, ad_out1, busy1, done1, cmd_ready1, rdata1};
        return o;
    endfunction

    // Phase index for cycle j (1-based after acceptance); 7 = back to idle.
    function automatic int phase_of(input int j, input int lens[7]);
        int cum = 0;
        for (int p = 0; p < 7; p++) begin
            if (j <= cum + lens[p]) return p;
            cum += lens[p];
        end
        return 7;
    endfunction

    // Pin picture of each phase: address phases drive addr, data phases drive
    // wdata on writes only, cs low only in the two strobe phases.
    function automatic obs_t model(input int p, input logic rwv, input logic [7:0] a,
                                   input logic [7:0] w, input logic [7:0] rdv);
        obs_t e;
        e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, BUF, rdv};
        case (p)
            0, 2: begin e.a_d = 1'b0; e.oe = 1'b1; e.ad = a; end
            1: begin e.a_d = 1'b0; e.cs = 1'b0; e.wr = 1'b0; e.oe = 1'b1; e.ad = a; end
            3, 5: if (!rwv) begin e.oe = 1'b1; e.ad = w; end
            4: begin
                e.cs = 1'b0;
                if (rwv) e.rd = 1'b0;
                else begin e.wr = 1'b0; e.oe = 1'b1; e.ad = w; end
            end
            6: e.done = 1'b1;
            7: begin e.busy = 1'b0; e.rdy = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // One full transaction on dut (which=0) or dut2 (which=1), checked every cycle.
    task automatic run_txn(input int which, input logic rwv, input logic [7:0] a,
                           input logic [7:0] w, input logic [7:0] d, output int done_j);
        int   lens[7];
        int   total, last_strobe, p;
        obs_t e, o;
        if (which == 0) lens = '{1, 2, 1, 1, 2, 1, 1};
        else            lens = '{1, 4, 1, 1, 3, 1, 1};
        total = 0;
        foreach (lens[i]) total += lens[i];
        last_strobe = lens[0] + lens[1] + lens[2] + lens[3] + lens[4];
        done_j = -1;
        rw = rwv; addr = a; wdata = w;
        if (which == 0) start = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        for (int j = 1; j <= total + 1; j++) begin
            if (j == last_strobe + 1 && rwv) exp_rd[which] = d;
            p = phase_of(j, lens);
            e = model(p, rwv, a, w, exp_rd[which]);
            o = sample(which);
            if (!e.oe) o.ad = 8'h00;
            if (o.done && done_j < 0) done_j = j;
            check($sformatf("txn%0d rw=%0b cyc%0d", which, rwv, j), 32'(o), 32'(e));
            // Bus only holds valid read data in the last strobe cycle.
            ad_in = (j == last_strobe) ? d : ~d;
            // Inputs wander after acceptance; the transaction must not notice.
            rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic pulse_start(input logic rwv, input logic [7:0] a, input logic [7:0] w);
        rw = rwv; addr = a; wdata = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t vecs[5];
    int   dj;
    int   n_done;
    int   done_at[$];
    obs_t idle_e, o;

    initial begin
        vecs[0] = '{1'b0, 8'h21, 8'h5A, 8'h00, 8'h00, 9};
        vecs[1] = '{1'b1, 8'h24, 8'h00, 8'hC3, 8'hC3, 9};
        vecs[2] = '{1'b0, 8'h7F, 8'hA5, 8'h11, 8'hC3, 9};
        vecs[3] = '{1'b1, 8'h00, 8'h66, 8'hFF, 8'hFF, 9};
        vecs[4] = '{1'b1, 8'hFF, 8'h99, 8'h00, 8'h00, 9};

        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        rw = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state over five idle cycles.
        idle_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset_idle%0d", i), 32'(sample(0)), 32'(idle_e));
            @(negedge clk);
        end
        check("reset_idle_dut2", 32'(sample(1)), 32'(idle_e));

        // Table vectors.
        foreach (vecs[i]) begin
            run_txn(0, vecs[i].rw, vecs[i].a, vecs[i].w, vecs[i].d, dj);
            check($sformatf("tbl%0d_done_cycle", i), 32'(dj), 32'(vecs[i].exp_done));
            check($sformatf("tbl%0d_rdata", i), 32'(rdata0), 32'(vecs[i].exp_rdata));
        end

        // Randomized transactions.
        for (int i = 0; i < 20; i++) begin
            run_txn(0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), dj);
            check($sformatf("rnd%0d_done_cycle", i), 32'(dj), 32'd9);
        end

        // Timing override instance.
        run_txn(1, 1'b0, 8'h33, 8'h44, 8'h00, dj);
        check("ovr_wr_done_cycle", 32'(dj), 32'd12);
        run_txn(1, 1'b1, 8'h35, 8'h00, 8'h96, dj);
        check("ovr_rd_done_cycle", 32'(dj), 32'd12);
        check("ovr_rd_rdata", 32'(rdata1), 32'h96);

`ifndef RTC_CMD_BUF_EN
        // start while busy is ignored: one done pulse, no second transaction.
        n_done = 0;
        pulse_start(1'b0, 8'h12, 8'h34);
        for (int j = 1; j <= 30; j++) begin
            if (j == 3) begin rw = 1'b1; addr = 8'h99; start = 1'b1; end
            else start = 1'b0;
            if (done0) n_done++;
            if (j == 4) check("ign_rdy_while_busy", 32'(cmd_ready0), 32'd0);
            if (j == 10) check("ign_busy_after_done", 32'(busy0), 32'd0);
            @(negedge clk);
        end
        check("ign_done_count", 32'(n_done), 32'd1);
`else
        // Second command buffered while busy chains right after DONE; third ignored.
        done_at.delete();
        ad_in = 8'h3C;
        pulse_start(1'b0, 8'h10, 8'h20);
        for (int j = 1; j <= 30; j++) begin
            start = 1'b0;
            if (j == 3) begin rw = 1'b1; addr = 8'h24; start = 1'b1; end
            if (j == 5) begin rw = 1'b0; addr = 8'h77; start = 1'b1; end
            if (done0) done_at.push_back(j);
            if (j == 4) check("buf_rdy_when_full", 32'(cmd_ready0), 32'd0);
            if (j == 10) check("buf_chain_addr", 32'({a_d0, ad_oe0, ad_out0}), 32'({1'b0, 1'b1, 8'h24}));
            if (j == 19) check("buf_no_third", 32'(busy0), 32'd0);
            @(negedge clk);
        end
        check("buf_done_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) begin
            check("buf_first_done", 32'(done_at[0]), 32'd9);
            check("buf_done_spacing", 32'(done_at[1] - done_at[0]), 32'd9);
        end
        check("buf_rdata", 32'(rdata0), 32'h3C);

        // Command arriving during the DONE cycle itself.
        done_at.delete();
        pulse_start(1'b0, 8'h01, 8'h02);
        for (int j = 1; j <= 25; j++) begin
            start = 1'b0;
            if (j == 9) begin rw = 1'b0; addr = 8'h5E; start = 1'b1; end
            if (done0) done_at.push_back(j);
            if (j == 10) check("buf_done_cycle_chain", 32'({a_d0, ad_out0}), 32'({1'b0, 8'h5E}));
            @(negedge clk);
        end
        check("buf_done_cycle_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) check("buf_done_cycle_second", 32'(done_at[1]), 32'd18);
`endif

        // Reset during STROBE aborts: idle pins next cycle, no done, rdata cleared.
        ad_in = 8'hC3;
        pulse_start(1'b1, 8'h24, 8'h00);
        for (int j = 1; j < 6; j++) @(negedge clk);
        check("rst_in_strobe", 32'({cs0, rd0}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_abort_idle", 32'(sample(0)), 32'(idle_e));
        reset = 1'b0;
        n_done = 0;
        for (int j = 0; j < 15; j++) begin
            if (done0) n_done++;
            @(negedge clk);
        end
        check("rst_abort_no_done", 32'(n_done), 32'd0);
        o = sample(0);
        check("rst_abort_rdata", 32'(o.rdata), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
